// File: rtl/score_arb_pkg.sv
// -----------------------------------------------------------------------------
// score_arb_pkg
// Shared types and defaults for the ScoreTracker submission arbiter.
//   state_e     : transaction FSM states (idle, load, request, settle, result)
//   DEF_*       : default tracker widths, request code and phase lengths
//   cnt_width() : width of the phase down-counter for a given hold/settle pair
// -----------------------------------------------------------------------------
package score_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam int         DEF_ID_W     = 2;
  localparam int         DEF_SCORE_W  = 14;
  localparam logic [3:0] DEF_REQ_CODE = 4'd5;
  localparam int         DEF_REQ_HOLD = 1;
  localparam int         DEF_SETTLE   = 10;

  // The counter is loaded with (length - 1) and counts down to zero, so it
  // only has to represent values up to max(hold, settle) - 1.
  function automatic int cnt_width(input int hold, input int settle);
    int longest;
    longest = (hold > settle) ? hold : settle;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_REQ_HOLD, DEF_SETTLE);

endpackage

// File: rtl/score_submit_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first requesting station at
// or above ptr, wrapping past the top back to station 0.
//   req       : per-station request vector
//   ptr       : station with highest priority this cycle
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : index of the granted station
//   any_grant : at least one station requested
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_PLAYERS = 4,
  localparam int IDX_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic [NUM_PLAYERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   any_grant
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_PLAYERS);
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/score_submit_arbiter.sv
// -----------------------------------------------------------------------------
// score_submit_arbiter
// Shares one ScoreTracker among NUM_PLAYERS stations. A submission is granted
// round-robin in IDLE, then the tracker transaction is sequenced:
// LOAD (id/score) -> REQ (score_req = REQ_CODE for REQ_HOLD cycles) ->
// SETTLE (SETTLE cycles) -> RESULT (one-cycle res_valid to the requester).
//
// Ports
//   clk, rst            : clock, synchronous active-low reset
//   sub_valid/sub_score : per-station submission (score i at [i*SCORE_W +: SCORE_W])
//   sub_ready           : one-hot grant pulse, score captured in that cycle
//   res_valid           : one-hot result pulse to the granted station
//   res_personal/global : winner flags, qualified by res_valid, held until next RESULT
//   busy                : high whenever the FSM is not in IDLE
//   trk_*               : ScoreTracker interface
//
// Build option
//   SCORE_ARB_ZERO_FILTER_EN : a granted score of zero skips the tracker and
//                              goes straight to RESULT with both flags clear.
// -----------------------------------------------------------------------------
module score_submit_arbiter
  import score_arb_pkg::*;
#(
  parameter int         NUM_PLAYERS = 4,
  parameter int         ID_W        = DEF_ID_W,
  parameter int         SCORE_W     = DEF_SCORE_W,
  parameter logic [3:0] REQ_CODE    = DEF_REQ_CODE,
  parameter int         REQ_HOLD    = DEF_REQ_HOLD,
  parameter int         SETTLE      = DEF_SETTLE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         sub_valid,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] sub_score,
  output logic [NUM_PLAYERS-1:0]         sub_ready,
  output logic [NUM_PLAYERS-1:0]         res_valid,
  output logic                           res_personal,
  output logic                           res_global,
  output logic                           busy,
  output logic [ID_W-1:0]                trk_player_id,
  output logic [SCORE_W-1:0]             trk_score,
  output logic [3:0]                     trk_score_req,
  input  logic                           trk_personal_winner,
  input  logic                           trk_global_winner
);

  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CNT_W = cnt_width(REQ_HOLD, SETTLE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               rp_q, rp_d;
  logic               rg_q, rg_d;

  logic [NUM_PLAYERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [SCORE_W-1:0]     sel_score;

  rr_arbiter #(
    .NUM_PLAYERS (NUM_PLAYERS)
  ) u_rr_arbiter (
    .req       (sub_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign sel_score = sub_score[arb_idx*SCORE_W +: SCORE_W];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    id_d          = id_q;
    score_d       = score_q;
    rp_d          = rp_q;
    rg_d          = rg_q;
    sub_ready     = '0;
    res_valid     = '0;
    trk_score_req = '0;

    case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while reset is asserted so no station sees a
        // handshake for a capture that will never happen.
        if (arb_any && rst) begin
          sub_ready = arb_grant;
          gidx_d    = arb_idx;
`ifdef SCORE_ARB_ZERO_FILTER_EN
          if (sel_score == '0) begin
            rp_d    = 1'b0;
            rg_d    = 1'b0;
            state_d = ST_RESULT;
          end else begin
            id_d    = ID_W'(arb_idx);
            score_d = sel_score;
            state_d = ST_LOAD;
          end
`else
          id_d    = ID_W'(arb_idx);
          score_d = sel_score;
          state_d = ST_LOAD;
`endif
        end
      end

      ST_LOAD: begin
        cnt_d   = CNT_W'(REQ_HOLD - 1);
        state_d = ST_REQ;
      end

      ST_REQ: begin
        trk_score_req = REQ_CODE;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          // Last settle cycle: tracker outputs are valid, register them.
          rp_d    = trk_personal_winner;
          rg_d    = trk_global_winner;
          state_d = ST_RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESULT: begin
        res_valid[gidx_q] = 1'b1;
        ptr_d   = (gidx_q == IDX_W'(NUM_PLAYERS - 1)) ? '0 : gidx_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      id_q    <= '0;
      score_q <= '0;
      rp_q    <= 1'b0;
      rg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      id_q    <= id_d;
      score_q <= score_d;
      rp_q    <= rp_d;
      rg_q    <= rg_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign trk_player_id = id_q;
  assign trk_score     = score_q;
  assign res_personal  = rp_q;
  assign res_global    = rg_q;

endmodule

// File: tb/tb_score_submit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_score_submit_arbiter
// Self-checking bench for score_submit_arbiter. A transaction-level reference
// model (grant cycle, fixed latency, round-robin pointer) predicts every
// output each cycle; scenario tasks add explicit cycle-exact checks.
// -----------------------------------------------------------------------------
module tb_score_submit_arbiter;

  localparam int NP = 4;
  localparam int SW = 14;
  localparam int RH = 1;
  localparam int ST = 10;
  localparam int L  = 2 + RH + ST;
`ifdef SCORE_ARB_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic        rp;
    logic        rg;
    logic        busy;
    logic [1:0]  id;
    logic [13:0] sc;
    logic [3:0]  req;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sub_valid;
  logic [55:0] sub_score;
  logic [3:0]  sub_ready;
  logic [3:0]  res_valid;
  logic        res_personal;
  logic        res_global;
  logic        busy;
  logic [1:0]  trk_player_id;
  logic [13:0] trk_score;
  logic [3:0]  trk_score_req;
  logic        trk_personal_winner;
  logic        trk_global_winner;

  always #5 clk = ~clk;

  score_submit_arbiter #(
    .NUM_PLAYERS (NP),
    .ID_W        (2),
    .SCORE_W     (SW),
    .REQ_CODE    (4'd5),
    .REQ_HOLD    (RH),
    .SETTLE      (ST)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sub_valid           (sub_valid),
    .sub_score           (sub_score),
    .sub_ready           (sub_ready),
    .res_valid           (res_valid),
    .res_personal        (res_personal),
    .res_global          (res_global),
    .busy                (busy),
    .trk_player_id       (trk_player_id),
    .trk_score           (trk_score),
    .trk_score_req       (trk_score_req),
    .trk_personal_winner (trk_personal_winner),
    .trk_global_winner   (trk_global_winner)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: one in-flight transaction at most.
  int          cyc = 0;
  logic        p_rst = 1'b0;
  logic [3:0]  p_v = '0;
  logic [55:0] p_sc = '0;
  logic        p_pw = 1'b0;
  logic        p_gw = 1'b0;
  int          m_ptr = 0;
  bit          m_act = 1'b0;
  int          m_g = 0;
  int          m_gc = 0;
  int          m_res = 0;
  bit          m_zero = 1'b0;
  logic [1:0]  m_id = '0;
  logic [13:0] m_sc = '0;
  logic        m_rp = 1'b0;
  logic        m_rg = 1'b0;

  outs_t hist_o[$];
  outs_t hist_e[$];

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NP; k++)
      if (v[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  // Apply the clock edge that closes cycle 'cyc' using that cycle's inputs.
  task automatic model_edge();
    int g;
    logic [13:0] s;
    if (!p_rst) begin
      m_ptr = 0; m_act = 1'b0; m_id = '0; m_sc = '0; m_rp = 1'b0; m_rg = 1'b0;
    end else if (m_act) begin
      if (cyc + 1 == m_res && !m_zero) begin
        m_rp = p_pw;
        m_rg = p_gw;
      end
      if (cyc == m_res) begin
        m_act = 1'b0;
        m_ptr = (m_g + 1) % NP;
      end
    end else begin
      g = rr_pick(p_v, m_ptr);
      if (g >= 0) begin
        s      = p_sc[g*SW +: SW];
        m_act  = 1'b1;
        m_g    = g;
        m_gc   = cyc;
        m_zero = ZF && (s == 14'd0);
        m_res  = cyc + (m_zero ? 1 : L);
        if (m_zero) begin
          m_rp = 1'b0;
          m_rg = 1'b0;
        end else begin
          m_id = 2'(g);
          m_sc = s;
        end
      end
    end
    cyc++;
  endtask

  // One clock cycle: advance model, drive inputs, predict and sample outputs.
  task automatic tick(input logic r, input logic [3:0] v, input logic [55:0] sc,
                      input logic pw, input logic gw, output outs_t o, output outs_t e);
    int g;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; sub_valid = v; sub_score = sc;
    trk_personal_winner = pw; trk_global_winner = gw;
    p_rst = r; p_v = v; p_sc = sc; p_pw = pw; p_gw = gw;
    e = '0;
    e.id = m_id; e.sc = m_sc; e.rp = m_rp; e.rg = m_rg;
    if (m_act) begin
      e.busy = 1'b1;
      if (!m_zero && cyc >= m_gc + 2 && cyc <= m_gc + 1 + RH) e.req = 4'd5;
      if (cyc == m_res) e.rv[m_g] = 1'b1;
    end else if (r) begin
      g = rr_pick(v, m_ptr);
      if (g >= 0) e.rdy[g] = 1'b1;
    end
    #3;
    o.rdy = sub_ready; o.rv = res_valid; o.rp = res_personal; o.rg = res_global;
    o.busy = busy; o.id = trk_player_id; o.sc = trk_score; o.req = trk_score_req;
  endtask

  // Single-station transaction driver; records observed/predicted outputs.
  task automatic drive_one(input int stn, input logic [13:0] score, input logic pw,
                           input logic gw, input int ncyc, output int t0);
    outs_t o, e;
    logic [55:0] sc;
    t0 = -1;
    hist_o.delete();
    hist_e.delete();
    for (int k = 0; k < ncyc; k++) begin
      sc = 56'({$urandom(), $urandom()});
      sc[stn*SW +: SW] = score;
      tick(1'b1, (t0 < 0) ? (4'b0001 << stn) : 4'b0000, sc, pw, gw, o, e);
      hist_o.push_back(o);
      hist_e.push_back(e);
      if (t0 < 0 && e.rdy[stn]) t0 = k;
    end
  endtask

  task automatic test_reset();
    outs_t o, e;
    bit saw_rv;
    int t0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 4'b1111, '0, 1'b1, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs_zero got=%h exp=0", o); end
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 4'b0000, '0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    checks++;
    if (o.busy !== 1'b0 || o.rv !== 4'b0) begin
      errors++; $display("FAIL reset_idle_quiet got busy=%b rv=%b exp busy=0 rv=0", o.busy, o.rv);
    end
    // Start a transaction and abort it mid-settle.
    t0 = -1;
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, (t0 < 0) ? 4'b0010 : 4'b0000, 56'd500 << SW, 1'b1, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_prep cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (t0 < 0 && e.rdy[1]) t0 = k;
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 4'b0000, '0, 1'b1, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_abort cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    tick(1'b1, 4'b0000, '0, 1'b1, 1'b1, o, e);
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_after_abort got=%h exp=0", o); end
    saw_rv = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 4'b0000, '0, 1'b1, 1'b1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_drop cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.rv != 4'b0) saw_rv = 1'b1;
    end
    checks++;
    if (saw_rv) begin errors++; $display("FAIL reset_dropped_result got res_valid pulse exp none"); end
  endtask

  task automatic test_single();
    int t0;
    drive_one(1, 14'd100, 1'b1, 1'b1, 18, t0);
    for (int k = 0; k < hist_o.size(); k++) begin
      checks++;
      if (hist_o[k] !== hist_e[k]) begin
        errors++; $display("FAIL single_model k=%0d got=%h exp=%h", k, hist_o[k], hist_e[k]);
      end
    end
    checks++;
    if (hist_o[0].rdy !== 4'b0010) begin errors++; $display("FAIL single_grant got=%b exp=0010", hist_o[0].rdy); end
    checks++;
    if (hist_o[1].id !== 2'd1 || hist_o[1].sc !== 14'd100 || hist_o[1].req !== 4'd0) begin
      errors++; $display("FAIL single_load got id=%0d sc=%0d req=%0d exp 1/100/0", hist_o[1].id, hist_o[1].sc, hist_o[1].req);
    end
    checks++;
    if (hist_o[2].req !== 4'd5 || hist_o[3].req !== 4'd0) begin
      errors++; $display("FAIL single_req got T+2=%0d T+3=%0d exp 5/0", hist_o[2].req, hist_o[3].req);
    end
    checks++;
    if (hist_o[12].rv !== 4'b0 || hist_o[13].rv !== 4'b0010 || hist_o[13].rp !== 1'b1 || hist_o[13].rg !== 1'b1) begin
      errors++; $display("FAIL single_result got T+12 rv=%b T+13 rv=%b p=%b g=%b exp 0000/0010/1/1",
                         hist_o[12].rv, hist_o[13].rv, hist_o[13].rp, hist_o[13].rg);
    end
  endtask

  task automatic test_flags();
    int t0;
    drive_one(1, 14'd88, 1'b0, 1'b0, 16, t0);
    for (int k = 0; k < hist_o.size(); k++) begin
      checks++;
      if (hist_o[k] !== hist_e[k]) begin
        errors++; $display("FAIL flags_model k=%0d got=%h exp=%h", k, hist_o[k], hist_e[k]);
      end
    end
    checks++;
    if (hist_o[13].rv !== 4'b0010 || hist_o[13].rp !== 1'b0 || hist_o[13].rg !== 1'b0) begin
      errors++; $display("FAIL flags_zero got rv=%b p=%b g=%b exp 0010/0/0", hist_o[13].rv, hist_o[13].rp, hist_o[13].rg);
    end
    drive_one(2, 14'd102, 1'b0, 1'b1, 16, t0);
    for (int k = 0; k < hist_o.size(); k++) begin
      checks++;
      if (hist_o[k] !== hist_e[k]) begin
        errors++; $display("FAIL station2_model k=%0d got=%h exp=%h", k, hist_o[k], hist_e[k]);
      end
    end
    checks++;
    if (hist_o[1].id !== 2'd2 || hist_o[1].sc !== 14'd102 || hist_o[13].rv !== 4'b0100 || hist_o[13].rg !== 1'b1) begin
      errors++; $display("FAIL station2 got id=%0d sc=%0d rv=%b g=%b exp 2/102/0100/1",
                         hist_o[1].id, hist_o[1].sc, hist_o[13].rv, hist_o[13].rg);
    end
  endtask

  task automatic test_all_request();
    outs_t o, e;
    logic [55:0] sc;
    int gl[$], gcyc[$], rl[$];
    int idx;
    tick(1'b0, 4'b0000, '0, 1'b0, 1'b0, o, e);
    for (int i = 0; i < NP; i++) sc[i*SW +: SW] = 14'($urandom_range(1, 16383));
    for (int k = 0; k < 60; k++) begin
      tick(1'b1, 4'b1111, sc, 1'($urandom()), 1'($urandom()), o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL all_model cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.rdy != 4'b0 && o.rv != 4'b0) begin
        checks++; errors++; $display("FAIL all_overlap got rdy=%b rv=%b exp disjoint", o.rdy, o.rv);
      end
      for (int i = 0; i < NP; i++) begin
        if (o.rdy[i]) begin gl.push_back(i); gcyc.push_back(k); sc[i*SW +: SW] = 14'($urandom_range(1, 16383)); end
        if (o.rv[i]) rl.push_back(i);
      end
    end
    checks++;
    if (gl.size() != 5) begin errors++; $display("FAIL all_grant_count got=%0d exp=5", gl.size()); end
    for (int n = 0; n < gl.size() && n < 5; n++) begin
      idx = n % NP;
      checks++;
      if (gl[n] != idx || gcyc[n] != n * (L + 1)) begin
        errors++; $display("FAIL all_order n=%0d got st=%0d cyc=%0d exp st=%0d cyc=%0d", n, gl[n], gcyc[n], idx, n * (L + 1));
      end
    end
    for (int n = 0; n < rl.size() && n < gl.size(); n++) begin
      checks++;
      if (rl[n] != gl[n]) begin errors++; $display("FAIL all_result_match n=%0d got=%0d exp=%0d", n, rl[n], gl[n]); end
    end
  endtask

  task automatic test_withdraw();
    outs_t o, e;
    int n0, n3, r0cyc;
    tick(1'b0, 4'b0000, '0, 1'b0, 1'b0, o, e);
    n0 = 0; n3 = 0; r0cyc = -1;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, (k == 0) ? 4'b1001 : 4'b0000, {14'd77, 28'd0, 14'd55}, 1'b1, 1'b0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL withdraw_model cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o.rdy[3] || o.rv[3]) n3++;
      if (o.rdy[0]) n0++;
      if (o.rv[0]) r0cyc = k;
    end
    checks++;
    if (n3 != 0 || n0 != 1 || r0cyc != L) begin
      errors++; $display("FAIL withdraw got st3_events=%0d st0_grants=%0d st0_res=%0d exp 0/1/%0d", n3, n0, r0cyc, L);
    end
  endtask

  task automatic test_zero();
    int t0;
    bit saw_req;
    drive_one(2, 14'd0, 1'b1, 1'b1, 18, t0);
    saw_req = 1'b0;
    for (int k = 0; k < hist_o.size(); k++) begin
      checks++;
      if (hist_o[k] !== hist_e[k]) begin
        errors++; $display("FAIL zero_model k=%0d got=%h exp=%h", k, hist_o[k], hist_e[k]);
      end
      if (hist_o[k].req != 4'd0) saw_req = 1'b1;
    end
`ifdef SCORE_ARB_ZERO_FILTER_EN
    checks++;
    if (hist_o[1].rv !== 4'b0100 || hist_o[1].rp !== 1'b0 || hist_o[1].rg !== 1'b0 || saw_req) begin
      errors++; $display("FAIL zero_filter got rv=%b p=%b g=%b req_seen=%b exp 0100/0/0/0",
                         hist_o[1].rv, hist_o[1].rp, hist_o[1].rg, saw_req);
    end
`else
    checks++;
    if (hist_o[1].rv !== 4'b0 || hist_o[13].rv !== 4'b0100 || hist_o[13].rp !== 1'b1 || !saw_req) begin
      errors++; $display("FAIL zero_full got T+1 rv=%b T+13 rv=%b p=%b req_seen=%b exp 0000/0100/1/1",
                         hist_o[1].rv, hist_o[13].rv, hist_o[13].rp, saw_req);
    end
`endif
  endtask

  task automatic test_random();
    outs_t o, e;
    logic [3:0]  pend, last_rdy;
    logic [55:0] sc;
    logic        r;
    int          ngr;
    pend = '0; last_rdy = '0; sc = '0; ngr = 0;
    for (int k = 0; k < 700; k++) begin
      for (int i = 0; i < NP; i++) begin
        if (last_rdy[i]) begin
          if ($urandom_range(0, 2) == 0)
            sc[i*SW +: SW] = ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
          else
            pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 5) == 0) begin
          pend[i] = 1'b1;
          sc[i*SW +: SW] = ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
        end else if (pend[i] && $urandom_range(0, 60) == 0) begin
          pend[i] = 1'b0;
        end
      end
      r = ($urandom_range(0, 299) != 0);
      tick(r, pend, sc, 1'($urandom()), 1'($urandom()), o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, o, e); end
      last_rdy = e.rdy;
      if (e.rdy != 4'b0) ngr++;
    end
    checks++;
    if (ngr < 20) begin errors++; $display("FAIL random_activity got grants=%0d exp>=20", ngr); end
  endtask

  initial begin
    rst = 1'b0;
    sub_valid = '0;
    sub_score = '0;
    trk_personal_winner = 1'b0;
    trk_global_winner = 1'b0;
    test_reset();
    test_single();
    test_flags();
    test_all_request();
    test_withdraw();
    test_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
